// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the mtm_Alu command sequencer: opcodes, FSM states,
// error bits, CRC polynomials and response-control helpers.
package mtm_alu_pkg;

  localparam int CRC4_LEN = 68;
  localparam int CRC3_LEN = 37;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_EXEC  = 3'd2,
    ST_GEN   = 3'd3,
    ST_SEND  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam int ERR_DATA_BIT = 2;
  localparam int ERR_CRC_BIT  = 1;
  localparam int ERR_OP_BIT   = 0;

  localparam logic [2:0] ERR_DATA = 3'b100;
  localparam logic [2:0] ERR_CRC  = 3'b010;
  localparam logic [2:0] ERR_OP   = 3'b001;

  // Polynomials without the implicit top term: x^4+x+1 and x^3+x+1.
  localparam logic [3:0] CRC4_POLY = 4'b0011;
  localparam logic [2:0] CRC3_POLY = 3'b011;

  function automatic logic op_is_valid(input logic [2:0] op);
    logic ok;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
      default:                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic even_parity(input logic [6:0] bits);
    return ^bits;
  endfunction

  function automatic logic [7:0] err_ctl(input logic [2:0] err);
    logic [6:0] upper;
    upper = {1'b1, err, err};
    return {upper, even_parity(upper)};
  endfunction

endpackage

// File: rtl/mtm_alu_crc_serial.sv
// Generic MSB-first bit-serial CRC LFSR; crc_step is the value the register
// takes once din has been shifted in, so callers can use the final bit early.
module mtm_alu_crc_serial #(
  parameter int              WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] crc,
  output logic [WIDTH-1:0] crc_step
);

  logic             feedback_s;
  logic [WIDTH-1:0] shifted_s;

  // one LFSR step over din
  always_comb begin
    feedback_s = din ^ crc[WIDTH-1];
    shifted_s  = {crc[WIDTH-2:0], 1'b0};
    if (feedback_s) begin
      crc_step = shifted_s ^ POLY;
    end else begin
      crc_step = shifted_s;
    end
  end

  // CRC register: cleared at frame start, advanced while enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= {WIDTH{1'b0}};
    end else if (clr) begin
      crc <= {WIDTH{1'b0}};
    end else if (en) begin
      crc <= crc_step;
    end
  end

endmodule

// File: rtl/mtm_alu_sequencer.sv
// Frame sequencer: validates one deserialized frame (framing, CRC4, opcode),
// drives the ALU, then returns a CRC3-protected result or an error response.
module mtm_alu_sequencer
  import mtm_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [7:0]  in_ctl,
  input  logic        in_frame_err,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic        alu_done,
  input  logic [31:0] alu_c,
  input  logic [3:0]  alu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_is_err,
  output logic [31:0] out_data,
  output logic [7:0]  out_ctl
);

  localparam logic [6:0] CHECK_LAST = 7'(CRC4_LEN - 1);
  localparam logic [6:0] GEN_LAST   = 7'(CRC3_LEN - 1);

  state_e        state_r;
  state_e        state_s;
  logic [6:0]    cnt_r;
  logic [31:0]   a_r;
  logic [31:0]   b_r;
  logic [31:0]   c_r;
  logic [2:0]    op_r;
  logic [3:0]    crc4_rx_r;
  logic [3:0]    flags_r;

  logic          accept_s;
  logic          done_s;
  logic          crc4_bad_s;
  logic [CRC4_LEN-1:0] crc4_bits_s;
  logic [CRC3_LEN-1:0] crc3_bits_s;
  logic [6:0]    crc4_idx_s;
  logic [5:0]    crc3_idx_s;
  logic          crc4_din_s;
  logic          crc3_din_s;
  logic [3:0]    crc4_reg_unused_s;
  logic [3:0]    crc4_step_s;
  logic [2:0]    crc3_reg_unused_s;
  logic [2:0]    crc3_step_s;
  logic          ctl_msb_unused_s;
  logic [2:0]    err_s;

  logic          in_ready_s;
  logic          alu_start_s;
  logic          out_valid_s;
  logic          out_is_err_s;
  logic [31:0]   out_data_s;
  logic [7:0]    out_ctl_s;

  assign ctl_msb_unused_s = in_ctl[7];
  assign accept_s   = (state_r == ST_IDLE) && in_valid;
  assign done_s     = (state_r == ST_EXEC) && alu_done;

  // Both CRCs walk their message MSB first, one bit per counter step.
  assign crc4_bits_s = {b_r, a_r, 1'b1, op_r};
  assign crc3_bits_s = {c_r, 1'b0, flags_r};
  assign crc4_idx_s  = CHECK_LAST - cnt_r;
  assign crc3_idx_s  = GEN_LAST[5:0] - cnt_r[5:0];
  assign crc4_din_s  = crc4_bits_s[crc4_idx_s];
  assign crc3_din_s  = crc3_bits_s[crc3_idx_s];
  assign crc4_bad_s  = (crc4_step_s != crc4_rx_r);

  assign alu_op = op_r;
  assign alu_a  = a_r;
  assign alu_b  = b_r;

  mtm_alu_crc_serial #(.WIDTH(4), .POLY(CRC4_POLY)) u_crc4 (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept_s),
    .en       (state_r == ST_CHECK),
    .din      (crc4_din_s),
    .crc      (crc4_reg_unused_s),
    .crc_step (crc4_step_s)
  );

  mtm_alu_crc_serial #(.WIDTH(3), .POLY(CRC3_POLY)) u_crc3 (
    .clk      (clk),
    .rst      (rst),
    .clr      (done_s),
    .en       (state_r == ST_GEN),
    .din      (crc3_din_s),
    .crc      (crc3_reg_unused_s),
    .crc_step (crc3_step_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_frame_err) begin
            state_s = ST_ERR;
          end else begin
            state_s = ST_CHECK;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (cnt_r == CHECK_LAST) begin
          if (crc4_bad_s || !op_is_valid(op_r)) begin
            state_s = ST_ERR;
          end else begin
            state_s = ST_EXEC;
          end
        end else begin
          state_s = ST_CHECK;
        end
      end
      ST_EXEC: begin
        if (alu_done) begin
          state_s = ST_GEN;
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_GEN: begin
        if (cnt_r == GEN_LAST) begin
          state_s = ST_SEND;
        end else begin
          state_s = ST_GEN;
        end
      end
      ST_SEND, ST_ERR: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // error code for a frame heading into ERR; framing errors only leave IDLE
  always_comb begin
    if (state_r == ST_IDLE) begin
      err_s = ERR_DATA;
    end else if (crc4_bad_s) begin
      err_s = ERR_CRC;
    end else begin
      err_s = ERR_OP;
    end
  end

  // output decode from the upcoming state; responses latch on entry and hold
  always_comb begin
    in_ready_s   = 1'b0;
    alu_start_s  = 1'b0;
    out_valid_s  = 1'b0;
    out_is_err_s = 1'b0;
    out_data_s   = 32'h0000_0000;
    out_ctl_s    = 8'h00;
    case (state_s)
      ST_IDLE: in_ready_s = 1'b1;
      ST_EXEC: alu_start_s = (state_r == ST_CHECK);
      ST_SEND: begin
        out_valid_s = 1'b1;
        if (state_r == ST_GEN) begin
          out_data_s = c_r;
          out_ctl_s  = {1'b0, flags_r, crc3_step_s};
        end else begin
          out_data_s = out_data;
          out_ctl_s  = out_ctl;
        end
      end
      ST_ERR: begin
        out_valid_s  = 1'b1;
        out_is_err_s = 1'b1;
        if (state_r == ST_ERR) begin
          out_ctl_s = out_ctl;
        end else begin
          out_ctl_s = err_ctl(err_s);
        end
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // frame capture, ALU result capture and shared bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= 32'h0000_0000;
      b_r       <= 32'h0000_0000;
      op_r      <= 3'b000;
      crc4_rx_r <= 4'h0;
      c_r       <= 32'h0000_0000;
      flags_r   <= 4'h0;
      cnt_r     <= 7'd0;
    end else begin
      if (accept_s) begin
        a_r       <= in_a;
        b_r       <= in_b;
        op_r      <= in_ctl[6:4];
        crc4_rx_r <= in_ctl[3:0];
      end
      if (done_s) begin
        c_r     <= alu_c;
        flags_r <= alu_flags;
      end
      if (accept_s || done_s) begin
        cnt_r <= 7'd0;
      end else if ((state_r == ST_CHECK) || (state_r == ST_GEN)) begin
        cnt_r <= cnt_r + 7'd1;
      end
    end
  end

  // output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready   <= 1'b1;
      alu_start  <= 1'b0;
      out_valid  <= 1'b0;
      out_is_err <= 1'b0;
      out_data   <= 32'h0000_0000;
      out_ctl    <= 8'h00;
    end else begin
      in_ready   <= in_ready_s;
      alu_start  <= alu_start_s;
      out_valid  <= out_valid_s;
      out_is_err <= out_is_err_s;
      out_data   <= out_data_s;
      out_ctl    <= out_ctl_s;
    end
  end

endmodule

// File: tb/tb_mtm_alu_sequencer.sv
// Randomized scoreboard bench for mtm_alu_sequencer with a polynomial-division
// CRC reference model and a behavioural ALU stub.
module tb_mtm_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = 32'h0;
  logic [31:0] in_b = 32'h0;
  logic [7:0]  in_ctl = 8'h0;
  logic        in_frame_err = 1'b0;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_done = 1'b0;
  logic [31:0] alu_c = 32'h0;
  logic [3:0]  alu_flags = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_is_err;
  logic [31:0] out_data;
  logic [7:0]  out_ctl;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
    logic [7:0]  ctl;
  } resp_t;

  resp_t       exp_q[$];
  resp_t       mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          start_cnt = 0;
  int          done_cyc = 0;
  logic        stub_on = 1'b1;
  logic [31:0] stub_c = 32'h0;
  logic [3:0]  stub_flags = 4'h0;
  int          stub_delay = 1;
  logic [7:0]  last_ctl = 8'h0;

  mtm_alu_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ctl(in_ctl), .in_frame_err(in_frame_err),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_c(alu_c), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_err(out_is_err),
    .out_data(out_data), .out_ctl(out_ctl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CRC as remainder of M(x)*x^n divided by the generator, by long division
  function automatic logic [3:0] model_crc4(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [71:0] r;
    r = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r = r ^ (72'h13 << (i - 4));
    return r[3:0];
  endfunction

  function automatic logic [2:0] model_crc3(input logic [31:0] c, input logic [3:0] flags);
    logic [39:0] r;
    r = {c, 1'b0, flags, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r = r ^ (40'hB << (i - 3));
    return r[2:0];
  endfunction

  function automatic logic [7:0] model_err_ctl(input logic [2:0] err);
    return {1'b1, err, err, ^{1'b1, err, err}};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (in_valid && in_ready) acc_cnt++;
    if (alu_start) start_cnt++;
  end

  // scoreboard monitor: compare every completed response against the queue
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      last_ctl = out_ctl;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_response: got ctl 0x%0h data 0x%0h, expected none", out_ctl, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_is_err", {31'b0, out_is_err}, {31'b0, mon_e.is_err});
        chk("resp_data", out_data, mon_e.data);
        chk("resp_ctl", {24'b0, out_ctl}, {24'b0, mon_e.ctl});
      end
    end
  end

  // behavioural ALU: answers each alu_start after stub_delay cycles
  initial begin
    forever begin
      @(negedge clk);
      if (alu_start && stub_on) begin
        repeat (stub_delay) @(posedge clk);
        #1;
        alu_done = 1'b1; alu_c = stub_c; alu_flags = stub_flags; done_cyc = cyc;
        @(posedge clk); #1;
        alu_done = 1'b0; alu_c = $urandom; alu_flags = 4'($urandom);
      end
    end
  end

  task automatic drive_frame(input logic [31:0] a, input logic [31:0] b, input logic [7:0] ctl,
                             input logic ferr, output int acc);
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_ctl = ctl; in_frame_err = ferr;
    @(negedge clk);
    chk("accept_ready", {31'b0, in_ready}, 32'd1);
    acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_ctl = 8'($urandom); in_frame_err = 1'b0;
  endtask

  task automatic wait_sig(input int which, input int bound, output int at);
    at = -1;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if ((which == 0 && alu_start) || (which == 1 && out_valid)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_wait%0d: got no event within %0d cycles, expected one", which, bound);
    end
  endtask

  task automatic handshake(input int rw);
    repeat (rw) @(posedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_resp", {31'b0, in_ready}, 32'd1);
    chk("valid_after_resp", {31'b0, out_valid}, 32'd0);
  endtask

  task automatic run_frame(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           input logic [3:0] flip, input logic ferr, input logic [31:0] c,
                           input logic [3:0] flags, input int dly, input int rw, input logic stall);
    logic  good;
    resp_t e;
    int    acc, st, ov, sc0, acc0;
    logic  stable;
    logic [40:0] snap;
    good = !ferr && (flip == 4'h0) && (op inside {3'b000, 3'b001, 3'b100, 3'b101});
    if (ferr)            e = '{is_err: 1'b1, data: 32'h0, ctl: model_err_ctl(3'b100)};
    else if (flip != 0)  e = '{is_err: 1'b1, data: 32'h0, ctl: model_err_ctl(3'b010)};
    else if (!good)      e = '{is_err: 1'b1, data: 32'h0, ctl: model_err_ctl(3'b001)};
    else                 e = '{is_err: 1'b0, data: c, ctl: {1'b0, flags, model_crc3(c, flags)}};
    exp_q.push_back(e);
    stub_c = c; stub_flags = flags; stub_delay = dly;
    sc0 = start_cnt;
    drive_frame(a, b, {1'b0, op, model_crc4(a, b, op) ^ flip}, ferr, acc);
    if (good) begin
      wait_sig(0, 200, st);
      if (st >= 0) begin
        chk("start_latency", st - acc, 32'd69);
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        chk("alu_op", {29'b0, alu_op}, {29'b0, op});
      end
      wait_sig(1, 200, ov);
      if (ov >= 0) chk("result_latency", ov - done_cyc, 32'd38);
    end else begin
      wait_sig(1, 200, ov);
      if (ov >= 0) chk("err_latency", ov - acc, ferr ? 32'd1 : 32'd69);
      chk("no_alu_start", start_cnt - sc0, 32'd0);
    end
    if (ov >= 0 && stall) begin
      snap = {out_is_err, out_data, out_ctl};
      acc0 = acc_cnt;
      stable = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_ctl = 8'h40; in_frame_err = 1'b0;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if ({out_is_err, out_data, out_ctl} !== snap || !out_valid || in_ready) stable = 1'b0;
      end
      @(posedge clk); #1 in_valid = 1'b0;
      chk("stall_stable", {31'b0, stable}, 32'd1);
      chk("stall_no_accept", acc_cnt - acc0, 32'd0);
    end
    if (ov >= 0) handshake(rw);
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $finish;
  end

  initial begin
    int   acc, st, sc0;
    logic quiet;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_alu_start", {31'b0, alu_start}, 32'd0);
    chk("rst_out_is_err", {31'b0, out_is_err}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_ctl", {24'b0, out_ctl}, 32'd0);

    run_frame(32'd1, 32'd2, 3'b100, 4'h0, 1'b0, 32'd3, 4'b0000, 3, 1, 1'b0);
    chk("add_out_ctl_flags", {28'b0, last_ctl[6:3]}, 32'd0);
    run_frame(32'd1, 32'd2, 3'b100, 4'h1, 1'b0, 32'd3, 4'b0000, 2, 0, 1'b0);
    chk("crc_err_ctl", {24'b0, last_ctl}, 32'hA5);
    run_frame(32'h1234_5678, 32'h9ABC_DEF0, 3'b010, 4'h0, 1'b0, 32'd0, 4'h0, 2, 2, 1'b0);
    chk("op_err_ctl", {24'b0, last_ctl}, 32'h93);
    run_frame(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b001, 4'h4, 1'b1, 32'd0, 4'h0, 2, 0, 1'b0);
    chk("data_err_ctl", {24'b0, last_ctl}, 32'hC9);
    run_frame(32'd0, 32'd1, 3'b101, 4'h0, 1'b0, 32'hFFFF_FFFF, 4'b1001, 5, 0, 1'b0);
    chk("sub_flags", {28'b0, last_ctl[6:3]}, 32'h9);
    run_frame(32'hA5A5_0000, 32'h0000_5A5A, 3'b000, 4'h0, 1'b0, 32'h0000_0000, 4'b0010, 1, 0, 1'b1);

    // reset during CHECK
    sc0 = start_cnt;
    drive_frame(32'd7, 32'd9, {1'b0, 3'b100, model_crc4(32'd7, 32'd9, 3'b100)}, 1'b0, acc);
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_check_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_check_out_valid", {31'b0, out_valid}, 32'd0);
    quiet = 1'b1;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      if (out_valid || alu_start || !in_ready) quiet = 1'b0;
    end
    chk("rst_check_dropped", {31'b0, quiet}, 32'd1);
    chk("rst_check_no_start", start_cnt - sc0, 32'd0);

    // reset during EXEC with a stray alu_done afterwards
    stub_on = 1'b0;
    drive_frame(32'd5, 32'd6, {1'b0, 3'b001, model_crc4(32'd5, 32'd6, 3'b001)}, 1'b0, acc);
    wait_sig(0, 200, st);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; alu_done = 1'b1; alu_c = 32'hCAFE_0001; alu_flags = 4'hF;
    @(posedge clk); #1 alu_done = 1'b0;
    quiet = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (out_valid || !in_ready) quiet = 1'b0;
    end
    chk("rst_exec_dropped", {31'b0, quiet}, 32'd1);
    stub_on = 1'b1;
    run_frame(32'd10, 32'd20, 3'b100, 4'h0, 1'b0, 32'd30, 4'b0000, 2, 0, 1'b0);

    for (int k = 0; k < 25; k++) begin
      logic [3:0] flip;
      flip = ($urandom_range(0, 4) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      run_frame($urandom, $urandom, 3'($urandom_range(0, 7)), flip, ($urandom_range(0, 9) == 0),
                $urandom, 4'($urandom_range(0, 15)), $urandom_range(1, 6), $urandom_range(0, 3), 1'b0);
    end

    repeat (5) @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
